mc_controller: RTL and testbench

//  Multicycle CPU control FSM: fetch/decode/execute sequencing for the 16-bit datapath.

---
 rtl/mc_controller_pkg.sv | 76 +++++++
 rtl/mc_controller_if.sv | 31 +++
 rtl/mc_controller_branch_cond.sv | 24 ++
 rtl/mc_controller.sv | 150 +++++++++++++++
 tb/tb_mc_controller.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle controller: instruction fields, datapath
// select codes, FSM state encoding and the DEC-state instruction decode.
package mc_controller_pkg;

  localparam logic [2:0] OPC_BR   = 3'b001;
  localparam logic [2:0] OPC_BLG  = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_BX   = 2'b00;
  localparam logic [1:0] OP_BLX  = 2'b10;
  localparam logic [1:0] OP_BL   = 2'b11;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_R7 = 2'b10;
  localparam logic [1:0] NSEL_RM = 2'b11;

  localparam logic [1:0] VSEL_MDATA  = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
  localparam logic [1:0] VSEL_PC1    = 2'b10;
  localparam logic [1:0] VSEL_C      = 2'b11;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_REL = 2'b01;
  localparam logic [1:0] PC_SEL_REG = 2'b10;

  typedef enum logic [4:0] {
    S_RST  = 5'd0,  S_IF1  = 5'd1,  S_IF2  = 5'd2,  S_UPD  = 5'd3,
    S_DEC  = 5'd4,  S_WIMM = 5'd5,  S_LA   = 5'd6,  S_LB   = 5'd7,
    S_EX   = 5'd8,  S_WR   = 5'd9,  S_ADR  = 5'd10, S_LDA  = 5'd11,
    S_MRD  = 5'd12, S_MWB  = 5'd13, S_SB   = 5'd14, S_SC   = 5'd15,
    S_MWR  = 5'd16, S_BR   = 5'd17, S_LNK  = 5'd18, S_BX   = 5'd19,
    S_BXR  = 5'd20, S_HALT = 5'd21, S_ERR  = 5'd22
  } state_e;

  // Unrecognised opcode/op pairs fall back to IF1 so they execute as no-ops.
  function automatic state_e decode_next(input logic [2:0] opcode, input logic [1:0] op);
    state_e nxt;
    nxt = S_IF1;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOVI)      nxt = S_WIMM;
        else if (op == OP_MOVR) nxt = S_LB;
      end
      OPC_ALU:          nxt = (op == OP_MVN) ? S_LB : S_LA;
      OPC_LDR, OPC_STR: nxt = S_LA;
      OPC_BR:           nxt = S_BR;
      OPC_BLG: begin
        if (op == OP_BL || op == OP_BLX) nxt = S_LNK;
        else if (op == OP_BX)            nxt = S_BX;
      end
      OPC_HALT:         nxt = S_HALT;
      default:          nxt = S_IF1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the controller (master) and the datapath/memory side (slave).
interface mc_controller_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] cond;
  logic       Z, N, V;
  logic       mem_ready;

  logic       write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] nsel, vsel;
  logic       load_pc, reset_pc;
  logic [1:0] pc_sel;
  logic       addr_sel, load_addr, load_ir;
  logic [1:0] mem_cmd;
  logic       halted, err;
  logic [4:0] state_out;

  modport master (
    input  opcode, op, cond, Z, N, V, mem_ready,
    output write, loada, loadb, loadc, loads, asel, bsel, nsel, vsel,
           load_pc, reset_pc, pc_sel, addr_sel, load_addr, load_ir, mem_cmd,
           halted, err, state_out
  );

  modport slave (
    output opcode, op, cond, Z, N, V, mem_ready,
    input  write, loada, loadb, loadc, loads, asel, bsel, nsel, vsel,
           load_pc, reset_pc, pc_sel, addr_sel, load_addr, load_ir, mem_cmd,
           halted, err, state_out
  );
endinterface

// File: rtl/mc_controller_branch_cond.sv
// Branch condition evaluation from IR cond field and status flags.
module branch_cond
  import mc_controller_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = Z;
      COND_NE: taken = ~Z;
      COND_LT: taken = N ^ V;
      COND_LE: taken = (N ^ V) | Z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle CPU control FSM with mem_ready wait states, timeout and sticky error.
// state | meaning
// RST   | PC := 0            IF1/IF2 | fetch (IF1 waits on mem)   UPD | PC := PC+1
// DEC   | decode             WIMM    | Rn := sximm8               LA/LB | load A/B
// EX    | ALU op             WR      | Rd := C                    ADR/LDA | data address
// MRD   | load wait          MWB     | Rd := mdata                SB/SC | store data
// MWR   | store wait         BR      | conditional PC update      LNK | R7 := PC+1
// BX    | A := Rd            BXR     | PC := A                    HALT/ERR | stopped
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input logic           clk,
  input logic           reset,
  mc_controller_if.master bus
);

  localparam bit               WAIT_EN  = (WAIT_MAX != 0);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  state_e           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             in_wait, timeout, cond_taken;
  logic             is_cmp, ex_asel, br_take;

  branch_cond u_branch_cond (
    .cond  (bus.cond),
    .Z     (bus.Z),
    .N     (bus.N),
    .V     (bus.V),
    .taken (cond_taken)
  );

  assign in_wait = (state == S_IF1) || (state == S_MRD) || (state == S_MWR);
  assign timeout = WAIT_EN && in_wait && !bus.mem_ready && (wait_cnt == WAIT_LIM);
  assign is_cmp  = (bus.opcode == OPC_ALU) && (bus.op == OP_CMP);
  assign ex_asel = ((bus.opcode == OPC_MOV) && (bus.op == OP_MOVR)) ||
                   ((bus.opcode == OPC_ALU) && (bus.op == OP_MVN));
  // BR is only reached from the branch group via BL, which always takes.
  assign br_take = cond_taken || (bus.opcode == OPC_BLG);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RST;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    wait_cnt_next = '0;
    if (WAIT_EN && in_wait && !bus.mem_ready && !timeout)
      wait_cnt_next = wait_cnt + CNT_W'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RST:  state_next = S_IF1;
      S_IF1:  if (bus.mem_ready) state_next = S_IF2;
              else if (timeout)  state_next = S_ERR;
      S_IF2:  state_next = S_UPD;
      S_UPD:  state_next = S_DEC;
      S_DEC:  state_next = decode_next(bus.opcode, bus.op);
      S_WIMM: state_next = S_IF1;
      S_LA:   state_next = (bus.opcode == OPC_ALU) ? S_LB : S_ADR;
      S_LB:   state_next = S_EX;
      S_EX:   state_next = is_cmp ? S_IF1 : S_WR;
      S_WR:   state_next = S_IF1;
      S_ADR:  state_next = S_LDA;
      S_LDA:  state_next = (bus.opcode == OPC_LDR) ? S_MRD : S_SB;
      S_MRD:  if (bus.mem_ready) state_next = S_MWB;
              else if (timeout)  state_next = S_ERR;
      S_MWB:  state_next = S_IF1;
      S_SB:   state_next = S_SC;
      S_SC:   state_next = S_MWR;
      S_MWR:  if (bus.mem_ready) state_next = S_IF1;
              else if (timeout)  state_next = S_ERR;
      S_BR:   state_next = S_IF1;
      S_LNK:  state_next = (bus.op == OP_BL) ? S_BR : S_BXR;
      S_BX:   state_next = S_BXR;
      S_BXR:  state_next = S_IF1;
      S_HALT: state_next = S_HALT;
      S_ERR:  state_next = S_ERR;
      default: state_next = S_RST;
    endcase
  end

  always_comb begin
    bus.write     = 1'b0;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.nsel      = NSEL_RN;
    bus.vsel      = VSEL_MDATA;
    bus.load_pc   = 1'b0;
    bus.reset_pc  = 1'b0;
    bus.pc_sel    = PC_SEL_INC;
    bus.addr_sel  = 1'b0;
    bus.load_addr = 1'b0;
    bus.load_ir   = 1'b0;
    bus.mem_cmd   = MEM_NONE;
    bus.halted    = 1'b0;
    bus.err       = 1'b0;
    case (state)
      S_RST:  begin bus.reset_pc = 1'b1; bus.load_pc = 1'b1; end
      S_IF1:  begin bus.addr_sel = 1'b1; bus.mem_cmd = MEM_READ; end
      S_IF2:  begin bus.addr_sel = 1'b1; bus.mem_cmd = MEM_READ; bus.load_ir = 1'b1; end
      S_UPD:  begin bus.load_pc = 1'b1; bus.pc_sel = PC_SEL_INC; end
      S_WIMM: begin bus.nsel = NSEL_RN; bus.vsel = VSEL_SXIMM8; bus.write = 1'b1; end
      S_LA:   begin bus.nsel = NSEL_RN; bus.loada = 1'b1; end
      S_LB:   begin bus.nsel = NSEL_RM; bus.loadb = 1'b1; end
      S_EX: begin
        bus.asel  = ex_asel;
        bus.loads = is_cmp;
        bus.loadc = ~is_cmp;
      end
      S_WR:   begin bus.nsel = NSEL_RD; bus.vsel = VSEL_C; bus.write = 1'b1; end
      S_ADR:  begin bus.bsel = 1'b1; bus.loadc = 1'b1; end
      S_LDA:  bus.load_addr = 1'b1;
      S_MRD:  bus.mem_cmd = MEM_READ;
      S_MWB: begin
        bus.mem_cmd = MEM_READ;
        bus.nsel    = NSEL_RD;
        bus.vsel    = VSEL_MDATA;
        bus.write   = 1'b1;
      end
      S_SB:   begin bus.nsel = NSEL_RD; bus.loadb = 1'b1; end
      S_SC:   begin bus.asel = 1'b1; bus.loadc = 1'b1; end
      S_MWR:  bus.mem_cmd = MEM_WRITE;
      S_BR:   begin bus.load_pc = br_take; bus.pc_sel = PC_SEL_REL; end
      S_LNK:  begin bus.nsel = NSEL_R7; bus.vsel = VSEL_PC1; bus.write = 1'b1; end
      S_BX:   begin bus.nsel = NSEL_RD; bus.loada = 1'b1; end
      S_BXR:  begin bus.load_pc = 1'b1; bus.pc_sel = PC_SEL_REG; end
      S_HALT: bus.halted = 1'b1;
      S_ERR:  begin bus.halted = 1'b1; bus.err = 1'b1; end
      default: ;
    endcase
  end

  assign bus.state_out = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: instruction table with hand-computed latencies
// and control pulse counts, plus sequences for reset, wait states and timeout.
module tb_mc_controller;
  import mc_controller_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  mc_controller_if bus();

  mc_controller #(.WAIT_MAX(15), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int opcode, op, cond, z, n, v;
    int lat, first, writes, loadpcs, asels, loadss, last_pcsel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, int opcode, int op, int cond, int z, int n, int v,
                              int lat, int first, int writes, int loadpcs, int asels,
                              int loadss, int last_pcsel);
    vec_t r;
    r.name = name; r.opcode = opcode; r.op = op; r.cond = cond;
    r.z = z; r.n = n; r.v = v; r.lat = lat; r.first = first; r.writes = writes;
    r.loadpcs = loadpcs; r.asels = asels; r.loadss = loadss; r.last_pcsel = last_pcsel;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int s, input int budget, input string name);
    int k = 0;
    while (int'(bus.state_out) != s && k < budget) begin
      step();
      k++;
    end
    check(name, int'(bus.state_out), s);
  endtask

  task automatic set_instr(input int opcode, input int op, input int cond,
                           input int z, input int n, input int v);
    bus.opcode = 3'(opcode);
    bus.op     = 2'(op);
    bus.cond   = 3'(cond);
    bus.Z      = 1'(z);
    bus.N      = 1'(n);
    bus.V      = 1'(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cycles, writes, lps, asels, loadss, lastps, first, mrd, bad_cyc;

    //            name     opc op cnd Z N V  lat first   wr lp as ls ps
    vecs.push_back(mk("ADD",  5, 0, 0, 0,0,0, 8, S_LA,   1, 1, 0, 0, 0));
    vecs.push_back(mk("CMP",  5, 1, 0, 0,0,0, 7, S_LA,   0, 1, 0, 1, 0));
    vecs.push_back(mk("AND",  5, 2, 0, 0,0,0, 8, S_LA,   1, 1, 0, 0, 0));
    vecs.push_back(mk("MVN",  5, 3, 0, 0,0,0, 7, S_LB,   1, 1, 1, 0, 0));
    vecs.push_back(mk("MOVR", 6, 0, 0, 0,0,0, 7, S_LB,   1, 1, 1, 0, 0));
    vecs.push_back(mk("MOVI", 6, 2, 0, 0,0,0, 5, S_WIMM, 1, 1, 0, 0, 0));
    vecs.push_back(mk("LDR",  3, 0, 0, 0,0,0, 9, S_LA,   1, 1, 0, 0, 0));
    vecs.push_back(mk("STR",  4, 0, 0, 0,0,0, 10, S_LA,  0, 1, 1, 0, 0));
    vecs.push_back(mk("B",    1, 0, 0, 0,0,0, 5, S_BR,   0, 2, 0, 0, 1));
    vecs.push_back(mk("BEQ_T",1, 0, 1, 1,0,0, 5, S_BR,   0, 2, 0, 0, 1));
    vecs.push_back(mk("BEQ_N",1, 0, 1, 0,0,0, 5, S_BR,   0, 1, 0, 0, 0));
    vecs.push_back(mk("BNE_T",1, 0, 2, 0,0,0, 5, S_BR,   0, 2, 0, 0, 1));
    vecs.push_back(mk("BLT_T",1, 0, 3, 0,1,0, 5, S_BR,   0, 2, 0, 0, 1));
    vecs.push_back(mk("BLT_N",1, 0, 3, 0,1,1, 5, S_BR,   0, 1, 0, 0, 0));
    vecs.push_back(mk("BLE_T",1, 0, 4, 1,0,0, 5, S_BR,   0, 2, 0, 0, 1));
    vecs.push_back(mk("BNV",  1, 0, 5, 1,1,0, 5, S_BR,   0, 1, 0, 0, 0));
    vecs.push_back(mk("BL",   2, 3, 2, 1,0,0, 6, S_LNK,  1, 2, 0, 0, 1));
    vecs.push_back(mk("BX",   2, 0, 0, 0,0,0, 6, S_BX,   0, 2, 0, 0, 2));
    vecs.push_back(mk("BLX",  2, 2, 0, 0,0,0, 6, S_LNK,  1, 2, 0, 0, 2));
    vecs.push_back(mk("NOP0", 0, 0, 0, 0,0,0, 4, S_IF1,  0, 1, 0, 0, 0));
    vecs.push_back(mk("NOP6", 6, 1, 0, 0,0,0, 4, S_IF1,  0, 1, 0, 0, 0));

    // Reset for three cycles, then ADD walked cycle by cycle.
    set_instr(0, 0, 0, 0, 0, 0);
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    step(); step(); step();
    check("rst_state", int'(bus.state_out), S_RST);
    check("rst_reset_pc", int'(bus.reset_pc), 1);
    check("rst_load_pc", int'(bus.load_pc), 1);
    set_instr(5, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check("if1_state", int'(bus.state_out), S_IF1);
    check("if1_reset_pc", int'(bus.reset_pc), 0);
    check("if1_load_pc", int'(bus.load_pc), 0);
    check("if1_addr_sel", int'(bus.addr_sel), 1);
    check("if1_mem_cmd", int'(bus.mem_cmd), 1);
    step();
    check("if2_state", int'(bus.state_out), S_IF2);
    check("if2_load_ir", int'(bus.load_ir), 1);
    step();
    check("upd_state", int'(bus.state_out), S_UPD);
    check("upd_load_pc", int'(bus.load_pc), 1);
    check("upd_reset_pc", int'(bus.reset_pc), 0);
    step();
    check("dec_state", int'(bus.state_out), S_DEC);
    step();
    check("add_la_loada", int'({bus.loada, bus.loadb, bus.loadc, bus.write}), 4'b1000);
    step();
    check("add_lb_loadb", int'({bus.loada, bus.loadb, bus.loadc, bus.write}), 4'b0100);
    check("add_lb_nsel", int'(bus.nsel), 3);
    step();
    check("add_ex_loadc", int'({bus.loada, bus.loadb, bus.loadc, bus.write}), 4'b0010);
    check("add_ex_asel", int'(bus.asel), 0);
    step();
    check("add_wr_write", int'({bus.loada, bus.loadb, bus.loadc, bus.write}), 4'b0001);
    check("add_wr_nsel", int'(bus.nsel), 1);
    check("add_wr_vsel", int'(bus.vsel), 3);
    step();
    check("add_back_if1", int'(bus.state_out), S_IF1);

    // Instruction table, each started from IF1 with mem_ready high.
    foreach (vecs[i]) begin
      set_instr(vecs[i].opcode, vecs[i].op, vecs[i].cond, vecs[i].z, vecs[i].n, vecs[i].v);
      cycles = 0; writes = 0; lps = 0; asels = 0; loadss = 0; lastps = 0; first = -1;
      while (cycles < 40) begin
        if (bus.write) writes++;
        if (bus.asel) asels++;
        if (bus.loads) loadss++;
        if (bus.load_pc) begin
          lps++;
          lastps = int'(bus.pc_sel);
        end
        step();
        cycles++;
        if (cycles == 4) first = int'(bus.state_out);
        if (bus.state_out == S_IF1) break;
      end
      check({vecs[i].name, "_latency"}, cycles, vecs[i].lat);
      check({vecs[i].name, "_first"}, first, vecs[i].first);
      check({vecs[i].name, "_writes"}, writes, vecs[i].writes);
      check({vecs[i].name, "_load_pc"}, lps, vecs[i].loadpcs);
      check({vecs[i].name, "_asel"}, asels, vecs[i].asels);
      check({vecs[i].name, "_loads"}, loadss, vecs[i].loadss);
      check({vecs[i].name, "_pc_sel"}, lastps, vecs[i].last_pcsel);
    end

    // LDR with mem_ready low for five cycles in MRD.
    set_instr(3, 0, 0, 0, 0, 0);
    wait_for(S_MRD, 20, "ldr_reach_mrd");
    bus.mem_ready = 1'b0;
    mrd = 1; bad_cyc = 0;
    if (bus.mem_cmd != 2'b01 || bus.addr_sel != 1'b0) bad_cyc++;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.state_out == S_MRD) mrd++;
      if (bus.mem_cmd != 2'b01 || bus.addr_sel != 1'b0) bad_cyc++;
    end
    bus.mem_ready = 1'b1;
    step();
    check("ldr_mrd_cycles", mrd, 6);
    check("ldr_mrd_bad_outputs", bad_cyc, 0);
    check("ldr_mwb_state", int'(bus.state_out), S_MWB);
    check("ldr_mwb_write", int'(bus.write), 1);
    check("ldr_mwb_vsel", int'(bus.vsel), 0);
    check("ldr_mwb_nsel", int'(bus.nsel), 1);
    step();
    check("ldr_back_if1", int'(bus.state_out), S_IF1);

    // mem_ready arriving in the very cycle the limit is reached still advances.
    set_instr(0, 0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 15; k++) step();
    check("limit_still_if1", int'(bus.state_out), S_IF1);
    bus.mem_ready = 1'b1;
    step();
    check("limit_ready_wins", int'(bus.state_out), S_IF2);
    wait_for(S_IF1, 10, "limit_back_if1");

    // mem_ready stuck low in IF1 -> ERR after 16 cycles, sticky until reset.
    bus.mem_ready = 1'b0;
    cycles = 1;
    while (bus.state_out == S_IF1 && cycles < 40) begin
      step();
      if (bus.state_out == S_IF1) cycles++;
    end
    check("timeout_if1_cycles", cycles, 16);
    check("timeout_state", int'(bus.state_out), S_ERR);
    check("timeout_err", int'(bus.err), 1);
    check("timeout_halted", int'(bus.halted), 1);
    bus.mem_ready = 1'b1;
    step(); step(); step();
    check("err_sticky", int'({bus.err, bus.halted, bus.state_out}), {2'b11, 5'(S_ERR)});
    reset = 1'b1;
    step();
    check("err_reset_state", int'(bus.state_out), S_RST);
    check("err_reset_err", int'(bus.err), 0);
    reset = 1'b0;
    step();

    // Reset while in WR kills the write.
    set_instr(5, 0, 0, 0, 0, 0);
    wait_for(S_WR, 20, "wr_reach");
    check("wr_write_before", int'(bus.write), 1);
    reset = 1'b1;
    step();
    check("wr_reset_state", int'(bus.state_out), S_RST);
    check("wr_reset_write", int'(bus.write), 0);
    reset = 1'b0;
    step();

    // HALT holds regardless of mem_ready until reset.
    set_instr(7, 0, 0, 0, 0, 0);
    wait_for(S_HALT, 20, "halt_reach");
    bad_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_ready = 1'(k);
      step();
      if (bus.state_out != S_HALT || bus.halted != 1'b1 || bus.err != 1'b0) bad_cyc++;
    end
    check("halt_hold", bad_cyc, 0);
    reset = 1'b1;
    step();
    check("halt_reset_state", int'(bus.state_out), S_RST);
    check("halt_reset_halted", int'(bus.halted), 0);
    reset = 1'b0;
    step();
    check("halt_reset_if1", int'(bus.state_out), S_IF1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
